// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank
//  Description : Bank of CHANNELS down-counting timers that share one free-
//                running tick prescaler. Each channel has COUNT, RELOAD, CTRL
//                and STATUS registers on the 16-bit peripheral bus, one-shot
//                or auto-reload operation and a per-channel expiry flag. The
//                enabled flags are ORed onto a single interrupt line.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_bank #(
  parameter int CLOCK_FREQUENCY  = 50_000_000,
  parameter int TICKS_PER_SECOND = 1000,
  parameter int CHANNELS         = 4,
  parameter int WIDTH            = 16,
  localparam int CH_BITS         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               wr_en,
  input  logic [CH_BITS+1:0] addr,
  input  logic [15:0]        data_in,
  output logic [15:0]        data_out,
  output logic               irq
);

  localparam int c_prescale_max = CLOCK_FREQUENCY / TICKS_PER_SECOND - 1;
  localparam int c_ps_w         = (c_prescale_max > 0) ? $clog2(c_prescale_max + 1) : 1;

  localparam logic [1:0] c_reg_count  = 2'd0;
  localparam logic [1:0] c_reg_reload = 2'd1;
  localparam logic [1:0] c_reg_ctrl   = 2'd2;
  localparam logic [1:0] c_reg_status = 2'd3;

  logic [c_ps_w-1:0]  r_prescale;
  logic               w_tick;
  logic [CH_BITS-1:0] w_ch;
  logic [1:0]         w_reg;
  logic [15:0]        w_rd [CHANNELS];
  logic [CHANNELS-1:0] w_irq_vec;

  assign w_ch  = addr[CH_BITS+1:2];
  assign w_reg = addr[1:0];

  // Free-running prescaler; bus activity never restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= c_ps_w'(c_prescale_max);
    end else if (r_prescale == '0) begin
      r_prescale <= c_ps_w'(c_prescale_max);
    end else begin
      r_prescale <= r_prescale - c_ps_w'(1);
    end
  end

  assign w_tick = (r_prescale == '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_run;
    logic             r_auto;
    logic             r_irq_en;
    logic             r_expired;
    logic             w_sel;
    logic             w_wr_count;
    logic             w_fire;
    logic             w_expire_set;

    assign w_sel        = en && wr_en && (w_ch == CH_BITS'(i));
    assign w_wr_count   = w_sel && (w_reg == c_reg_count);
    // Terminal count reached on a tick; a COUNT write in the same cycle cancels it.
    assign w_fire       = w_tick && r_run && (r_count == WIDTH'(1));
    assign w_expire_set = w_fire && !w_wr_count;

    // COUNT: bus write has priority over the tick-driven decrement/reload.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= '0;
      end else if (w_wr_count) begin
        r_count <= data_in[WIDTH-1:0];
      end else if (w_tick && r_run) begin
        if (r_count > WIDTH'(1)) begin
          r_count <= r_count - WIDTH'(1);
        end else if (w_fire) begin
          r_count <= r_auto ? r_reload : '0;
        end
      end
    end

    // RELOAD and CTRL registers; a tick this cycle still sees the old CTRL.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_reload <= '0;
        r_run    <= 1'b0;
        r_auto   <= 1'b0;
        r_irq_en <= 1'b0;
      end else begin
        if (w_sel && (w_reg == c_reg_reload)) begin
          r_reload <= data_in[WIDTH-1:0];
        end
        if (w_sel && (w_reg == c_reg_ctrl)) begin
          r_run    <= data_in[0];
          r_auto   <= data_in[1];
          r_irq_en <= data_in[2];
        end
      end
    end

    // Expiry flag: write-1-to-clear, a simultaneous new expiry wins.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_expired <= 1'b0;
      end else if (w_expire_set) begin
        r_expired <= 1'b1;
      end else if (w_sel && (w_reg == c_reg_status) && data_in[0]) begin
        r_expired <= 1'b0;
      end
    end

    // Per-channel read word, zero-extended to the bus width.
    always_comb begin
      w_rd[i] = '0;
      case (w_reg)
        c_reg_count:  w_rd[i] = 16'(r_count);
        c_reg_reload: w_rd[i] = 16'(r_reload);
        c_reg_ctrl:   w_rd[i] = {13'b0, r_irq_en, r_auto, r_run};
        default:      w_rd[i] = {15'b0, r_expired};
      endcase
    end

    assign w_irq_vec[i] = r_expired & r_irq_en;
  end

  // Channel select for reads; indices with no channel return zero.
  always_comb begin
    data_out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_ch == CH_BITS'(k)) begin
        data_out = w_rd[k];
      end
    end
  end

  assign irq = |w_irq_vec;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_bank
//  Description : Self-checking bench for timer_bank. Stimulus pushes expected
//                read values into a scoreboard queue and raises a sample
//                event; a separate monitor pops and compares against the bus
//                read data or the interrupt line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_bank;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        irq;

  timer_bank #(
    .CLOCK_FREQUENCY (10),
    .TICKS_PER_SECOND(2),
    .CHANNELS        (4),
    .WIDTH           (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct packed {
    logic        is_irq;
    logic [7:0]  tag;
    logic [3:0]  addr;
    logic [15:0] exp;
  } sb_t;

  sb_t  sb [$];
  sb_t  cur;
  event sample_ev;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   base = 0;
  logic [15:0] actual;

  // Edge counter used to schedule stimulus relative to reset release.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares each sampled output against the oldest expectation.
  always begin
    @(sample_ev);
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL sb_underflow: sample with no expectation queued");
    end else begin
      cur    = sb.pop_front();
      actual = cur.is_irq ? {15'b0, irq} : data_out;
      if (actual !== cur.exp) begin
        tests_failed++;
        $display("FAIL t%0d_%s_a%0h: got %h, expected %h (cycle %0d)",
                 cur.tag, cur.is_irq ? "irq" : "reg", cur.addr, actual, cur.exp, cyc - base);
      end
    end
  end

  task automatic goto(input int k);
    while ((cyc - base) < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write that lands on edge k; returns just after that edge.
  task automatic wr_at(input int k, input int ch, input int rg, input logic [15:0] d);
    goto(k - 1);
    en      = 1'b1;
    wr_en   = 1'b1;
    addr    = {2'(ch), 2'(rg)};
    data_in = d;
    @(posedge clk);
    #1;
    en      = 1'b0;
    wr_en   = 1'b0;
  endtask

  task automatic chk(input int tn, input int ch, input int rg, input logic [15:0] exp);
    addr = {2'(ch), 2'(rg)};
    #1;
    sb.push_back('{is_irq: 1'b0, tag: 8'(tn), addr: addr, exp: exp});
    -> sample_ev;
    #1;
  endtask

  task automatic chk_irq(input int tn, input logic exp);
    #1;
    sb.push_back('{is_irq: 1'b1, tag: 8'(tn), addr: 4'h0, exp: {15'b0, exp}});
    -> sample_ev;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;

    // Load some state, then pulse reset mid-cycle and check it clears at once.
    wr_at(1, 1, 0, 16'd3);
    wr_at(2, 1, 1, 16'd9);
    wr_at(3, 1, 2, 16'd7);
    chk(0, 1, 0, 16'd3);
    chk(0, 1, 1, 16'd9);
    chk(0, 1, 2, 16'd7);
    #10;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        chk(1, c, r, 16'd0);
      end
    end
    chk_irq(1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;

    // First tick lands on edge 5 after release.
    wr_at(1, 0, 0, 16'd1);
    wr_at(2, 0, 2, 16'h0005);
    goto(4);
    chk(1, 0, 0, 16'd1);
    chk_irq(1, 1'b0);
    goto(5);
    chk(1, 0, 0, 16'd0);
    chk(1, 0, 3, 16'd1);
    chk_irq(1, 1'b1);
    wr_at(6, 0, 3, 16'h0001);
    chk(1, 0, 3, 16'd0);
    chk_irq(1, 1'b0);
    wr_at(7, 0, 2, 16'h0000);

    // One-shot on ch1.
    wr_at(8, 1, 0, 16'd3);
    wr_at(9, 1, 2, 16'h0005);
    goto(10);
    chk(2, 1, 0, 16'd2);
    goto(15);
    chk(2, 1, 0, 16'd1);
    chk(2, 1, 3, 16'd0);
    chk_irq(2, 1'b0);
    goto(20);
    chk(2, 1, 0, 16'd0);
    chk(2, 1, 3, 16'd1);
    chk_irq(2, 1'b1);
    goto(25);
    chk(2, 1, 0, 16'd0);
    wr_at(26, 1, 3, 16'h0001);
    chk(2, 1, 3, 16'd0);
    chk_irq(2, 1'b0);
    wr_at(27, 1, 2, 16'h0000);

    // Auto-reload on ch2; CTRL written on a tick edge uses the old CTRL.
    wr_at(28, 2, 1, 16'd2);
    wr_at(29, 2, 0, 16'd1);
    wr_at(30, 2, 2, 16'h0007);
    chk(3, 2, 0, 16'd1);
    chk(3, 2, 3, 16'd0);
    goto(35);
    chk(3, 2, 0, 16'd2);
    chk(3, 2, 3, 16'd1);
    chk_irq(3, 1'b1);
    goto(40);
    chk(3, 2, 0, 16'd1);
    wr_at(45, 2, 3, 16'h0001);
    chk(3, 2, 0, 16'd2);
    chk(3, 2, 3, 16'd1);
    wr_at(46, 2, 3, 16'h0001);
    chk(3, 2, 3, 16'd0);
    chk_irq(3, 1'b0);
    wr_at(47, 2, 2, 16'h0000);
    wr_at(48, 2, 1, 16'd6);
    chk(3, 2, 0, 16'd2);
    chk(3, 2, 1, 16'd6);

    // COUNT write colliding with an expiring tick.
    wr_at(49, 0, 0, 16'd1);
    wr_at(51, 0, 2, 16'h0005);
    wr_at(55, 0, 0, 16'd7);
    chk(4, 0, 0, 16'd7);
    chk(4, 0, 3, 16'd0);
    chk_irq(4, 1'b0);
    goto(60);
    chk(4, 0, 0, 16'd6);
    wr_at(61, 0, 2, 16'h0000);

    // Gating: stopped channel holds; expiry with irq_en=0 keeps irq low.
    wr_at(62, 3, 0, 16'd5);
    goto(82);
    chk(5, 3, 0, 16'd5);
    wr_at(83, 3, 0, 16'd1);
    wr_at(84, 3, 2, 16'h0001);
    goto(85);
    chk(5, 3, 0, 16'd0);
    chk(5, 3, 3, 16'd1);
    chk_irq(5, 1'b0);
    wr_at(86, 3, 2, 16'h0005);
    chk_irq(5, 1'b1);
    wr_at(87, 3, 2, 16'h0001);
    chk_irq(5, 1'b0);
    chk(5, 3, 3, 16'd1);
    wr_at(88, 3, 3, 16'h0001);
    chk(5, 3, 3, 16'd0);
    wr_at(89, 3, 2, 16'h0000);

    // Two channels expiring on the same tick.
    wr_at(91, 0, 0, 16'd1);
    wr_at(92, 1, 0, 16'd1);
    wr_at(93, 0, 2, 16'h0005);
    wr_at(94, 1, 2, 16'h0005);
    goto(95);
    chk(6, 0, 3, 16'd1);
    chk(6, 1, 3, 16'd1);
    chk_irq(6, 1'b1);
    wr_at(96, 0, 3, 16'h0001);
    chk(6, 0, 3, 16'd0);
    chk_irq(6, 1'b1);
    wr_at(97, 1, 3, 16'h0001);
    chk(6, 1, 3, 16'd0);
    chk_irq(6, 1'b0);

    // Unused CTRL bits read zero, full-width COUNT, zero COUNT holds under auto-reload.
    wr_at(98, 2, 2, 16'hFFFA);
    chk(7, 2, 2, 16'h0002);
    wr_at(99, 2, 0, 16'hFFFF);
    chk(7, 2, 0, 16'hFFFF);
    chk(7, 2, 3, 16'h0000);
    wr_at(101, 2, 0, 16'd0);
    wr_at(102, 2, 2, 16'h0007);
    goto(105);
    chk(7, 2, 0, 16'd0);
    chk(7, 2, 3, 16'd0);
    chk(7, 0, 0, 16'd0);
    chk_irq(7, 1'b0);

    #5;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
